// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream arbiter path.
//   state_e         : lock FSM state (IDLE / LOCKED)
//   onehot_lowest   : keeps only the lowest set bit of a request/grant vector
//   onehot_to_idx   : binary index of a one-hot vector
// Helpers operate on MAX_STREAMS-wide vectors; callers size-cast in and out.
package stream_arb_pkg;

    localparam int MAX_STREAMS = 32;
    localparam int MAX_IDX_W   = $clog2(MAX_STREAMS);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // v & -v isolates the lowest set bit; zero stays zero.
    function automatic logic [MAX_STREAMS-1:0] onehot_lowest(input logic [MAX_STREAMS-1:0] v);
        return v & (~v + 1'b1);
    endfunction

    // OR of the indices of all set bits: exact for one-hot, 0 for zero.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_STREAMS-1:0] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_STREAMS; i++) begin
            if (v[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready register stage.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : accept i_data this cycle (caller only loads when o_can_load)
//   i_data       : payload to capture
//   i_ready      : downstream ready
//   o_valid      : registered valid
//   o_data       : registered payload, held while o_valid & !i_ready
//   o_can_load   : stage is empty or being popped this cycle
module stream_out_reg #(
    parameter int PW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [PW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [PW-1:0] o_data,
    output logic          o_can_load
);

    logic          r_valid;
    logic [PW-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // A pop and a new load may coincide, giving full throughput.
    assign o_can_load = !r_valid || i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

endmodule

// File: rtl/stream_grant_mux.sv
// Downstream stage of the stream arbiter: exposes requests to the external
// priority arbiter, latches its grant at packet start, holds the lock until
// the s_last beat transfers, and forwards the locked stream through a
// registered valid/ready stage.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_data/s_last/s_ready : per-stream inputs, stream i data on
//                       s_data[i*T_DATA_WIDTH +: T_DATA_WIDTH]
//   req               : requests to arbiter (IDLE only)
//   grant             : one-hot or zero grant from arbiter
//   m_valid/m_data/m_last/m_ready : registered output stream
//   m_id              : source stream index (only with STREAM_MUX_ID_EN)
// Build option: define STREAM_MUX_ID_EN to add the m_id output.
// STREAM_COUNT must not exceed stream_arb_pkg::MAX_STREAMS.
module stream_grant_mux
    import stream_arb_pkg::*;
#(
    parameter int STREAM_COUNT = 2,
    parameter int T_DATA_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [STREAM_COUNT-1:0]              s_valid,
    input  logic [STREAM_COUNT*T_DATA_WIDTH-1:0] s_data,
    input  logic [STREAM_COUNT-1:0]              s_last,
    output logic [STREAM_COUNT-1:0]              s_ready,
    output logic [STREAM_COUNT-1:0]              req,
    input  logic [STREAM_COUNT-1:0]              grant,
    output logic                                 m_valid,
    output logic [T_DATA_WIDTH-1:0]              m_data,
    output logic                                 m_last,
`ifdef STREAM_MUX_ID_EN
    output logic [$clog2(STREAM_COUNT)-1:0]      m_id,
`endif
    input  logic                                 m_ready
);

    state_e                  r_state;
    logic [STREAM_COUNT-1:0] r_sel;

    logic [STREAM_COUNT-1:0] w_grant_lo;
    logic [T_DATA_WIDTH-1:0] w_data;
    logic                    w_last;
    logic                    w_xfer;
    logic                    w_can_load;

    // Illegal multi-hot grant resolves to its lowest set bit.
    assign w_grant_lo = STREAM_COUNT'(onehot_lowest(MAX_STREAMS'(grant)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|grant) begin
                        r_sel   <= w_grant_lo;
                        r_state <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Lock persists through any s_valid gap until the last beat moves.
                    if (w_xfer && w_last) begin
                        r_sel   <= '0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // req is masked by rst_n so the arbiter sees no request while reset is held.
    always_comb begin
        req     = '0;
        s_ready = '0;
        if (r_state == IDLE) req     = s_valid & {STREAM_COUNT{rst_n}};
        else                 s_ready = r_sel & {STREAM_COUNT{w_can_load}};
    end

    assign w_xfer = |(s_valid & s_ready);
    assign w_last = |(s_last & r_sel);

    // One-hot AND-OR mux; r_sel is zero in IDLE so the mux output is zero.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            w_data = w_data | (s_data[i*T_DATA_WIDTH +: T_DATA_WIDTH] & {T_DATA_WIDTH{r_sel[i]}});
        end
    end

`ifdef STREAM_MUX_ID_EN
    localparam int IDW = $clog2(STREAM_COUNT);
    localparam int PW  = T_DATA_WIDTH + 1 + IDW;
    logic [IDW-1:0] w_idx;
    assign w_idx = IDW'(onehot_to_idx(MAX_STREAMS'(r_sel)));
`else
    localparam int PW  = T_DATA_WIDTH + 1;
`endif

    logic [PW-1:0] w_payload;
    logic [PW-1:0] w_q;

`ifdef STREAM_MUX_ID_EN
    assign w_payload = {w_idx, w_last, w_data};
    assign {m_id, m_last, m_data} = w_q;
`else
    assign w_payload = {w_last, w_data};
    assign {m_last, m_data} = w_q;
`endif

    stream_out_reg #(.PW(PW)) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_xfer),
        .i_data     (w_payload),
        .i_ready    (m_ready),
        .o_valid    (m_valid),
        .o_data     (w_q),
        .o_can_load (w_can_load)
    );

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == IDLE && grant != '0) |-> $onehot(grant));

endmodule

// File: tb/tb_stream_grant_mux.sv
module tb_stream_grant_mux;

    logic        clk;
    logic        rst_n;
    logic [1:0]  s_valid;
    logic [15:0] s_data;
    logic [1:0]  s_last;
    logic [1:0]  s_ready;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready;
`ifdef STREAM_MUX_ID_EN
    logic [0:0]  m_id;
`endif

    int n_vec = 0;
    int n_err = 0;

    stream_grant_mux #(.STREAM_COUNT(2), .T_DATA_WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .req     (req),
        .grant   (grant),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
`ifdef STREAM_MUX_ID_EN
        .m_id    (m_id),
`endif
        .m_ready (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 2'b11;
        s_data  = {8'hB1, 8'hA1};
        s_last  = 2'b00;
        grant   = 2'b00;
        m_ready = 1'b1;

        // reset state, with both streams already valid
        repeat (3) cyc();
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data",  m_data,  0);
        chk("rst_m_last",  m_last,  0);
        chk("rst_req",     req,     0);
        chk("rst_s_ready", s_ready, 0);
`ifdef STREAM_MUX_ID_EN
        chk("rst_m_id", m_id, 0);
`endif
        rst_n = 1'b1;
        #1;
        chk("idle_req",     req,     2'b11);
        chk("idle_s_ready", s_ready, 2'b00);

        // test 1: stream0 three-beat packet
        grant = 2'b01;
        cyc(); grant = 2'b00; #1;
        chk("t1_lock_req",     req,     2'b00);
        chk("t1_lock_s_ready", s_ready, 2'b01);
        chk("t1_lock_m_valid", m_valid, 0);
        cyc(); s_data[7:0] = 8'hA2; #1;
        chk("t1_a1_valid",   m_valid, 1);
        chk("t1_a1_data",    m_data,  8'hA1);
        chk("t1_a1_last",    m_last,  0);
        chk("t1_a1_s_ready", s_ready, 2'b01);
`ifdef STREAM_MUX_ID_EN
        chk("t1_a1_id", m_id, 0);
`endif
        cyc(); s_data[7:0] = 8'hA3; s_last = 2'b01; #1;
        chk("t1_a2_data",    m_data,  8'hA2);
        chk("t1_a2_s_ready", s_ready, 2'b01);
        chk("t1_a2_req",     req,     2'b00);
        cyc(); s_valid = 2'b10; s_last = 2'b00; grant = 2'b10; #1;
        chk("t1_a3_data",    m_data,  8'hA3);
        chk("t1_a3_last",    m_last,  1);
        chk("t1_a3_valid",   m_valid, 1);
        chk("t1_idle_req",   req,     2'b10);
        chk("t1_idle_ready", s_ready, 2'b00);

        // test 2: stream1 after one arbitration bubble
        cyc(); grant = 2'b00; #1;
        chk("t2_bubble_valid", m_valid, 0);
        chk("t2_s_ready",      s_ready, 2'b10);
        chk("t2_req",          req,     2'b00);
        cyc(); s_data[15:8] = 8'hB2; #1;
        chk("t2_b1_valid", m_valid, 1);
        chk("t2_b1_data",  m_data,  8'hB1);
        chk("t2_b1_last",  m_last,  0);
`ifdef STREAM_MUX_ID_EN
        chk("t2_b1_id", m_id, 1);
`endif

        // test 3: downstream stall for 4 cycles
        m_ready = 1'b0; #1;
        chk("t3_stall_s_ready", s_ready, 2'b00);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk("t3_hold_valid",   m_valid, 1);
            chk("t3_hold_data",    m_data,  8'hB1);
            chk("t3_hold_s_ready", s_ready, 2'b00);
        end
        m_ready = 1'b1; #1;
        chk("t3_resume_s_ready", s_ready, 2'b10);
        cyc(); s_data[15:8] = 8'hB3; s_last = 2'b10; #1;
        chk("t3_b2_valid", m_valid, 1);
        chk("t3_b2_data",  m_data,  8'hB2);
        chk("t3_b2_last",  m_last,  0);
`ifdef STREAM_MUX_ID_EN
        chk("t3_b2_id", m_id, 1);
`endif
        cyc(); s_valid = 2'b01; s_data[7:0] = 8'hC1; s_last = 2'b01; grant = 2'b01; #1;
        chk("t3_b3_data", m_data, 8'hB3);
        chk("t3_b3_last", m_last, 1);
        chk("t3_idle_req", req,   2'b01);

        // test 4: back-to-back single-beat packets
        cyc(); #1;
        chk("t4_lock1_valid", m_valid, 0);
        chk("t4_lock1_ready", s_ready, 2'b01);
        chk("t4_lock1_req",   req,     2'b00);
        cyc(); s_data[7:0] = 8'hC2; #1;
        chk("t4_c1_valid", m_valid, 1);
        chk("t4_c1_data",  m_data,  8'hC1);
        chk("t4_c1_last",  m_last,  1);
        chk("t4_idle_req", req,     2'b01);
        chk("t4_idle_rdy", s_ready, 2'b00);
        cyc(); #1;
        chk("t4_lock2_valid", m_valid, 0);
        chk("t4_lock2_ready", s_ready, 2'b01);
        cyc(); grant = 2'b00; s_valid = 2'b00; s_last = 2'b00; #1;
        chk("t4_c2_valid", m_valid, 1);
        chk("t4_c2_data",  m_data,  8'hC2);
        chk("t4_c2_req",   req,     2'b00);

        // test 5: locked stream goes idle while the other stream waits
        s_valid = 2'b11; s_data = {8'hE1, 8'hD1}; grant = 2'b01;
        cyc(); grant = 2'b00; #1;
        chk("t5_lock_req",   req,     2'b00);
        chk("t5_lock_ready", s_ready, 2'b01);
        cyc(); s_valid = 2'b10; s_data[7:0] = 8'hD2; #1;
        chk("t5_d1_data", m_data, 8'hD1);
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            chk("t5_gap_req",   req,     2'b00);
            chk("t5_gap_valid", m_valid, 0);
            chk("t5_gap_ready", s_ready, 2'b01);
        end
        s_valid = 2'b11; s_last = 2'b01;
        cyc(); #1;
        chk("t5_d2_valid", m_valid, 1);
        chk("t5_d2_data",  m_data,  8'hD2);
        chk("t5_d2_last",  m_last,  1);
        chk("t5_idle_req", req,     2'b11);

        // test 6: reset in the middle of a stream1 packet
        grant = 2'b10;
        cyc(); grant = 2'b00; #1;
        chk("t6_lock_ready", s_ready, 2'b10);
        cyc(); #1;
        chk("t6_e1_valid", m_valid, 1);
        chk("t6_e1_data",  m_data,  8'hE1);
`ifdef STREAM_MUX_ID_EN
        chk("t6_e1_id", m_id, 1);
`endif
        rst_n = 1'b0; #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_data",  m_data,  0);
        chk("t6_rst_req",   req,     2'b00);
        chk("t6_rst_ready", s_ready, 2'b00);
        cyc(); rst_n = 1'b1; #1;
        chk("t6_post_req",   req,     2'b11);
        chk("t6_post_ready", s_ready, 2'b00);
        chk("t6_post_valid", m_valid, 0);
        grant = 2'b01;
        cyc(); grant = 2'b00; #1;
        chk("t6_relock_ready", s_ready, 2'b01);
        chk("t6_relock_req",   req,     2'b00);
        cyc(); #1;
        chk("t6_d2_data", m_data, 8'hD2);
        chk("t6_d2_last", m_last, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
